// File: rtl/mig_port_arbiter_pkg.sv
// Shared constants and state type for the MIG port arbiter.
package mig_port_arbiter_pkg;

  // Requester slots on the DDR port
  localparam int unsigned REQ_WEIGHT = 0;
  localparam int unsigned REQ_BIAS   = 1;
  localparam int unsigned REQ_DATA   = 2;
  localparam int unsigned REQ_WB     = 3;

  // MIG app_cmd encodings
  localparam logic [2:0] APP_CMD_WRITE = 3'b000;
  localparam logic [2:0] APP_CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mig_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i.
module mig_port_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [IW-1:0]    idx_o
);

  logic [IW-1:0] cand;

  // Scan requesters starting from the pointer, wrapping modulo N_REQ
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IW'((32'(ptr_i) + i) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mig_port_arbiter.sv
// Round-robin arbiter sharing one MIG user port between N_REQ burst requesters.
module mig_port_arbiter
  import mig_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DDR_ADDR_LEN = 32,
  parameter int unsigned SINGLE_LEN   = 24,
  parameter int unsigned BEAT_BYTES   = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ*DDR_ADDR_LEN-1:0]  req_addr,
  input  logic [N_REQ*SINGLE_LEN-1:0]    req_len,
  input  logic [N_REQ-1:0]               req_wr,
  output logic [N_REQ-1:0]               gnt,
  output logic [N_REQ-1:0]               done,
  output logic                           busy,
  output logic                           app_en,
  output logic [2:0]                     app_cmd,
  output logic [DDR_ADDR_LEN-1:0]        app_addr,
  input  logic                           app_rdy,
  input  logic                           app_rd_data_valid,
  output logic [N_REQ-1:0]               rd_valid,
  input  logic [N_REQ-1:0]               wr_valid,
  output logic [N_REQ-1:0]               wr_ready,
  output logic                           app_wdf_wren,
  output logic                           app_wdf_end,
  input  logic                           app_wdf_rdy
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [DDR_ADDR_LEN-1:0] ADDR_INC = DDR_ADDR_LEN'(BEAT_BYTES);
  localparam logic [SINGLE_LEN-1:0]   CNT_ONE  = SINGLE_LEN'(1);

  arb_state_e              state_q, state_d;
  logic [N_REQ-1:0]        gnt_q, gnt_d;
  logic [IW-1:0]           gidx_q, gidx_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [DDR_ADDR_LEN-1:0] addr_q, addr_d;
  logic [SINGLE_LEN-1:0]   len_q, len_d;
  logic [SINGLE_LEN-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [SINGLE_LEN-1:0]   data_cnt_q, data_cnt_d;
  logic                    wr_q, wr_d;

  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic                    xfer_active;
  logic                    data_open;
  logic                    beat_fire;

  mig_port_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Port-side outputs decoded from the current state and latched transfer
  always_comb begin
    xfer_active  = (state_q == ST_CMD) || (state_q == ST_DRAIN);
    data_open    = xfer_active && (data_cnt_q < len_q);
    busy         = (state_q != ST_IDLE);
    gnt          = xfer_active ? gnt_q : '0;
    done         = (state_q == ST_DONE) ? gnt_q : '0;
    // A zero-length grant sits in CMD for one cycle with the command count already satisfied
    app_en       = (state_q == ST_CMD) && (cmd_cnt_q != len_q);
    app_cmd      = (app_en && !wr_q) ? APP_CMD_READ : APP_CMD_WRITE;
    app_addr     = app_en ? addr_q : '0;
    rd_valid     = (xfer_active && !wr_q && app_rd_data_valid) ? gnt_q : '0;
    wr_ready     = (data_open && wr_q && app_wdf_rdy) ? gnt_q : '0;
    app_wdf_wren = |(wr_valid & wr_ready);
    app_wdf_end  = app_wdf_wren;
    beat_fire    = wr_q ? app_wdf_wren : (app_rd_data_valid && data_open);
  end

  // Next-state: arbitration in IDLE, command issue in CMD, data completion in DRAIN
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cmd_cnt_d  = cmd_cnt_q;
    data_cnt_d = data_cnt_q;
    wr_d       = wr_q;

    if (beat_fire) begin
      data_cnt_d = data_cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d         = ST_CMD;
          gidx_d          = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          addr_d          = req_addr[pick_idx*DDR_ADDR_LEN +: DDR_ADDR_LEN];
          len_d           = req_len[pick_idx*SINGLE_LEN +: SINGLE_LEN];
          wr_d            = req_wr[pick_idx];
          cmd_cnt_d       = '0;
          data_cnt_d      = '0;
        end
      end
      ST_CMD: begin
        if (len_q == '0) begin
          state_d = ST_DONE;
        end else if (app_rdy) begin
          addr_d    = addr_q + ADDR_INC;
          cmd_cnt_d = cmd_cnt_q + CNT_ONE;
          if (cmd_cnt_d == len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (data_cnt_q == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and transfer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cmd_cnt_q  <= '0;
      data_cnt_q <= '0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cmd_cnt_q  <= cmd_cnt_d;
      data_cnt_q <= data_cnt_d;
      wr_q       <= wr_d;
    end
  end

endmodule
